scmp_mem_arbiter: RTL and testbench
===================================

SCMP_MEM_ARBITER -- requirements
Module: scmp_mem_arbiter

Interface
REQ-001 Parameter WR_MASK, 16'h0FFA, per-4K-page CPU write enable; bit n enables page n, so pages 1 and 3..B are writable.
REQ-002 Parameter HOST_WP, 1'b0, when 1 the host port also obeys WR_MASK.
REQ-003 clk  in  1  single system clock; all logic is on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cpu_ads_n  in  1  CPU address strobe, active low; page and flags are on cpu_dout.
REQ-006 cpu_rd_n / cpu_wr_n  in  1 each  CPU read and write strobes, active low.
REQ-007 cpu_addr  in  12  CPU low address.
REQ-008 cpu_dout  in  8  CPU data out; carries {flags, page} during ADS.
REQ-009 cpu_din  out  8  read data to the CPU.
REQ-010 cpu_hold  out  1  stall request to the CPU, active high.
REQ-011 cpu_flags  out  4  latched {H,D,I,R} flags.
REQ-012 host_req / host_we  in  1 each  host (loader/debug) request and write select.
REQ-013 host_addr  in  16; host_wdata  in  8.
REQ-014 host_ack  out  1  one-cycle completion pulse; host_rdata  out  8.
REQ-015 ram_addr  out  16; ram_we  out  1; ram_wdata  out  8.
REQ-016 ram_rdata  in  8  synchronous RAM data, valid one cycle after ram_addr.
REQ-017 wp_err  out  1  one-cycle pulse on a write that was blocked.

Function
REQ-018 While cpu_ads_n=0 is sampled, the block SHALL register page<=cpu_dout[3:0] and cpu_flags<=cpu_dout[7:4], and SHALL set cpu_pend.
REQ-019 The FSM SHALL have states IDLE, CPU_ACC, HOST_ADR, HOST_DAT.
REQ-020 In IDLE, if cpu_pend=1 and (rd_n=0 or wr_n=0), the FSM SHALL go to CPU_ACC; otherwise, if host_req=1, it SHALL go to HOST_ADR; CPU wins on a tie.
REQ-021 In CPU_ACC: ram_addr={page,cpu_addr}; ram_we=!cpu_wr_n & WR_MASK[page]; ram_wdata=cpu_dout.
REQ-022 CPU_ACC SHALL return to IDLE and clear cpu_pend on the first cycle in which both cpu_rd_n and cpu_wr_n are 1.
REQ-023 cpu_din SHALL equal ram_rdata while cpu_rd_n=0, and 8'hFF otherwise.
REQ-024 HOST_ADR SHALL drive ram_addr=host_addr and ram_we=host_we (masked when HOST_WP=1), then go to HOST_DAT.
REQ-025 HOST_DAT SHALL register host_rdata<=ram_rdata, pulse host_ack for one cycle, and go to IDLE; the host access takes 2 cycles from grant to ack.
REQ-026 host_req SHALL be held by the host until host_ack; host_addr and host_we SHALL be stable for that whole time.
REQ-027 cpu_hold SHALL be 1 while the FSM is in HOST_ADR or HOST_DAT and cpu_pend=1; the worst case is 2 cycles.
REQ-028 After HOST_DAT, if cpu_pend=1, the FSM SHALL go to CPU_ACC before any new host grant, so the host cannot starve the CPU.
REQ-029 A write with its mask bit 0 SHALL keep ram_we=0 and pulse wp_err for one cycle per write strobe edge.
REQ-030 In IDLE: ram_we=0, and ram_addr holds its last value.

Reset
REQ-031 On rst=1 the block SHALL set: state=IDLE, cpu_pend=0, page=0, cpu_flags=0, cpu_hold=0, host_ack=0, host_rdata=0, ram_we=0, wp_err=0, ram_addr=0.
REQ-032 A reset during a host access SHALL abort it with no host_ack; the host re-issues the request.

Structure
REQ-033 The package scmp_pkg SHALL hold the FSM state enum, the PAGE_W=4 constant, and the default WR_MASK value.
REQ-034 The page/flag latch SHALL be the sub-module scmp_ads_latch; the rest of the block is flat.

Verification
REQ-035 CPU read: ADS with cpu_dout=8'h2C, cpu_addr=12'h345, RAM[0xC345]=8'h5A -> cpu_flags=4'h2, ram_addr=16'hC345, and cpu_din=8'h5A while rd_n=0.
REQ-036 CPU write: page 1, address 12'h010, data 8'hA5 -> RAM[0x1010]=8'hA5. Page 2 write -> ram_we stays 0, wp_err pulses once.
REQ-037 Host write, then read: write 0x2000<-8'h77, then read -> host_ack 2 cycles after each grant, host_rdata=8'h77.
REQ-038 Collision: host granted, then CPU ADS in HOST_ADR -> cpu_hold=1 for at most 2 cycles, then the CPU access completes before the next host grant.
REQ-039 Tie: host_req and CPU strobe in the same IDLE cycle -> the CPU is served first, and host_ack follows after the CPU cycle ends.
REQ-040 Reset in HOST_DAT -> no host_ack pulse, all outputs take their REQ-031 values on the next cycle.

Source files
------------

// File: rtl/scmp_pkg.sv
// Shared types and constants for the SC/MP memory arbiter: FSM states,
// page width and the default per-page CPU write mask.
package scmp_pkg;

  localparam int          PAGE_W          = 4;
  localparam logic [15:0] WR_MASK_DEFAULT = 16'h0FFA;

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    HOST_ADR,
    HOST_DAT
  } state_t;

endpackage

// File: rtl/scmp_ads_latch.sv
// Captures the page and the {H,D,I,R} flags the CPU multiplexes onto its data
// bus during the address strobe, and tracks the resulting pending access.
module scmp_ads_latch
  import scmp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ads_n,
  input  logic [7:0]        dout,
  input  logic              pend_clr,
  output logic [PAGE_W-1:0] page,
  output logic [3:0]        flags,
  output logic              pend
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      page  <= '0;
      flags <= '0;
      pend  <= 1'b0;
    end else if (!ads_n) begin
      page  <= dout[PAGE_W-1:0];
      flags <= dout[7:4];
      pend  <= 1'b1;
    end else if (pend_clr) begin
      pend  <= 1'b0;
    end
  end

endmodule

// File: rtl/scmp_mem_arbiter.sv
// Shares one synchronous RAM between the paged SC/MP CPU bus and a host
// loader/debug port; the CPU has priority and holds off new host grants.
module scmp_mem_arbiter
  import scmp_pkg::*;
#(
  parameter logic [15:0] WR_MASK = WR_MASK_DEFAULT,
  parameter logic        HOST_WP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ads_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_hold,
  output logic [3:0]  cpu_flags,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        wp_err
);

  state_t            state;
  logic [PAGE_W-1:0] page;
  logic              cpu_pend;
  logic              cpu_first;
  logic              wr_seen;
  logic              cpu_go;
  logic              cpu_done;
  logic              cpu_wr;
  logic              cpu_wr_ok;
  logic              host_go;
  logic              host_wr_ok;

  scmp_ads_latch u_ads_latch (
    .clk      (clk),
    .rst      (rst),
    .ads_n    (cpu_ads_n),
    .dout     (cpu_dout),
    .pend_clr (cpu_done),
    .page     (page),
    .flags    (cpu_flags),
    .pend     (cpu_pend)
  );

  assign cpu_go     = (state == IDLE) && cpu_pend && (!cpu_rd_n || !cpu_wr_n);
  assign cpu_done   = (state == CPU_ACC) && cpu_rd_n && cpu_wr_n;
  assign cpu_wr     = (cpu_go || (state == CPU_ACC)) && !cpu_wr_n;
  assign cpu_wr_ok  = WR_MASK[page];
  // host_ack is still high the cycle after HOST_DAT; that blocks an instant
  // re-grant on the request the host has not yet dropped
  assign host_go    = (state == IDLE) && !cpu_go && host_req && !host_ack && !cpu_first;
  assign host_wr_ok = !HOST_WP || WR_MASK[host_addr[15:12]];

  assign cpu_din  = cpu_rd_n ? 8'hFF : ram_rdata;
  assign cpu_hold = cpu_pend && ((state == HOST_ADR) || (state == HOST_DAT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_first  <= 1'b0;
      wr_seen    <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      wp_err     <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      wr_seen  <= cpu_wr;
      // one pulse per strobe: only the first cycle of a blocked write reports
      wp_err   <= (cpu_wr && !cpu_wr_ok && !wr_seen) ||
                  (host_go && host_we && !host_wr_ok);

      if (cpu_go || ((state == CPU_ACC) && !cpu_done)) begin
        ram_addr  <= {page, cpu_addr};
        ram_we    <= cpu_wr && cpu_wr_ok;
        ram_wdata <= cpu_dout;
      end else if (host_go) begin
        ram_addr  <= host_addr;
        ram_we    <= host_we && host_wr_ok;
        ram_wdata <= host_wdata;
      end else begin
        ram_we    <= 1'b0;
      end

      // a CPU that strobed during a host access goes before the next host grant
      if (state == HOST_DAT) begin
        cpu_first <= cpu_pend;
      end else if (cpu_go || !cpu_pend) begin
        cpu_first <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cpu_go) begin
            state <= CPU_ACC;
          end else if (host_go) begin
            state <= HOST_ADR;
          end
        end
        CPU_ACC: begin
          if (cpu_done) begin
            state <= IDLE;
          end
        end
        HOST_ADR: begin
          state <= HOST_DAT;
        end
        HOST_DAT: begin
          host_rdata <= ram_rdata;
          host_ack   <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scmp_mem_arbiter.sv
// Self-checking bench: directed vector table, hand-built collision/tie/reset
// sequences, and concurrent random CPU and host traffic against a memory model.
module tb_scmp_mem_arbiter;

  localparam logic [15:0] MASK      = 16'h0FFA;
  localparam int          CPU_TICKS = 5;
  // one edge to be granted, then two cycles from grant to ack
  localparam int          HOST_LAT  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ads_n, cpu_rd_n, cpu_wr_n;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpu_hold;
  logic [3:0]  cpu_flags;
  logic        host_req, host_we, host_ack;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        wp_err;

  int total = 0;
  int bad   = 0;
  int wp_cnt = 0, we_cnt = 0, hold_cnt = 0, ack_cnt = 0;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    logic [7:0]  ads;
    logic [11:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    logic [3:0]  exp_flags;
    logic [15:0] exp_ram_addr;
    int          exp_wp;
    logic        exp_we;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  scmp_mem_arbiter #(.WR_MASK(MASK), .HOST_WP(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ads_n  (cpu_ads_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_hold   (cpu_hold),
    .cpu_flags  (cpu_flags),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .wp_err     (wp_err)
  );

  // synchronous RAM, read data one cycle after the address
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (wp_err === 1'b1)   wp_cnt++;
    if (ram_we === 1'b1)   we_cnt++;
    if (cpu_hold === 1'b1) hold_cnt++;
    if (host_ack === 1'b1) ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic [7:0] ads, input logic [11:0] a, input logic wr,
                            input logic [7:0] wd, output logic [7:0] rd);
    cpu_ads_n = 1'b0;
    cpu_dout  = ads;
    cpu_addr  = a;
    tick();
    cpu_ads_n = 1'b1;
    if (wr) begin
      cpu_dout = wd;
      cpu_wr_n = 1'b0;
    end else begin
      cpu_rd_n = 1'b0;
    end
    repeat (CPU_TICKS) tick();
    rd = cpu_din;
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
    tick();
    if (wr && MASK[ads[3:0]]) ref_mem[{ads[3:0], a}] = wd;
  endtask

  task automatic host_access(input logic we, input logic [15:0] a, input logic [7:0] wd,
                             output logic [7:0] rd, output int lat);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = wd;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (host_ack !== 1'b1 && lat < 30);
    check("host ack seen", 32'(host_ack), 32'(1'b1));
    rd = host_rdata;
    host_req = 1'b0;
    tick();
    if (we) ref_mem[a] = wd;
  endtask

  initial begin
    logic [7:0] rd;
    int lat, wp0, we0, hold0, ack0;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     <= pat(16'(i));
      ref_mem[i]  = pat(16'(i));
    end
    mem[16'hC345]     <= 8'h5A;
    ref_mem[16'hC345]  = 8'h5A;

    //           ads    addr    wr    wdata  exp_rd flags  ram_addr  wp we
    vecs[0]  = '{8'h2C, 12'h345, 1'b0, 8'h00, 8'h5A, 4'h2, 16'hC345, 0, 1'b0};
    vecs[1]  = '{8'h31, 12'h010, 1'b1, 8'hA5, 8'h00, 4'h3, 16'h1010, 0, 1'b1};
    vecs[2]  = '{8'h01, 12'h010, 1'b0, 8'h00, 8'hA5, 4'h0, 16'h1010, 0, 1'b0};
    vecs[3]  = '{8'h92, 12'h010, 1'b1, 8'h33, 8'h00, 4'h9, 16'h2010, 1, 1'b0};
    vecs[4]  = '{8'h02, 12'h010, 1'b0, 8'h00, 8'h30, 4'h0, 16'h2010, 0, 1'b0};
    vecs[5]  = '{8'hFB, 12'hFFF, 1'b1, 8'hC3, 8'h00, 4'hF, 16'hBFFF, 0, 1'b1};
    vecs[6]  = '{8'h0B, 12'hFFF, 1'b0, 8'h00, 8'hC3, 4'h0, 16'hBFFF, 0, 1'b0};
    vecs[7]  = '{8'h50, 12'h0AB, 1'b1, 8'h12, 8'h00, 4'h5, 16'h00AB, 1, 1'b0};
    vecs[8]  = '{8'h00, 12'h0AB, 1'b0, 8'h00, 8'hAB, 4'h0, 16'h00AB, 0, 1'b0};
    vecs[9]  = '{8'h4F, 12'h001, 1'b1, 8'h99, 8'h00, 4'h4, 16'hF001, 1, 1'b0};
    vecs[10] = '{8'h0F, 12'h001, 1'b0, 8'h00, 8'hF1, 4'h0, 16'hF001, 0, 1'b0};
    vecs[11] = '{8'h73, 12'h000, 1'b1, 8'h11, 8'h00, 4'h7, 16'h3000, 0, 1'b1};
    vecs[12] = '{8'h03, 12'h000, 1'b0, 8'h00, 8'h11, 4'h0, 16'h3000, 0, 1'b0};
    vecs[13] = '{8'h6C, 12'h222, 1'b1, 8'hEE, 8'h00, 4'h6, 16'hC222, 1, 1'b0};
    vecs[14] = '{8'h0C, 12'h222, 1'b0, 8'h00, 8'hE0, 4'h0, 16'hC222, 0, 1'b0};

    rst = 1'b1;
    cpu_ads_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    cpu_addr = '0; cpu_dout = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) tick();
    check("reset ram_addr",   32'(ram_addr),   32'h0);
    check("reset ram_we",     32'(ram_we),     32'h0);
    check("reset host_ack",   32'(host_ack),   32'h0);
    check("reset host_rdata", 32'(host_rdata), 32'h0);
    check("reset cpu_hold",   32'(cpu_hold),   32'h0);
    check("reset cpu_flags",  32'(cpu_flags),  32'h0);
    check("reset wp_err",     32'(wp_err),     32'h0);
    check("reset cpu_din",    32'(cpu_din),    32'hFF);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      wp0 = wp_cnt;
      we0 = we_cnt;
      cpu_access(vecs[i].ads, vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d flags", i),    32'(cpu_flags), 32'(vecs[i].exp_flags));
      check($sformatf("vec%0d ram_addr", i), 32'(ram_addr),  32'(vecs[i].exp_ram_addr));
      check($sformatf("vec%0d wp pulses", i), 32'(wp_cnt - wp0), 32'(vecs[i].exp_wp));
      check($sformatf("vec%0d ram_we seen", i), 32'(we_cnt != we0), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d din idle", i), 32'(cpu_din), 32'hFF);
    end

    host_access(1'b1, 16'h2000, 8'h77, rd, lat);
    check("host wr latency", 32'(lat), 32'(HOST_LAT));
    host_access(1'b0, 16'h2000, 8'h00, rd, lat);
    check("host rd latency", 32'(lat), 32'(HOST_LAT));
    check("host rd data", 32'(rd), 32'h77);

    // collision: ADS lands while the host is in its address cycle
    hold0 = hold_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h4812;
    tick();
    check("coll grant addr", 32'(ram_addr), 32'h4812);
    cpu_ads_n = 1'b0; cpu_dout = 8'h56; cpu_addr = 12'h044;
    tick();
    cpu_ads_n = 1'b1;
    check("coll hold", 32'(cpu_hold), 32'h1);
    tick();
    check("coll ack", 32'(host_ack), 32'h1);
    check("coll host data", 32'(host_rdata), 32'(ref_mem[16'h4812]));
    check("coll hold released", 32'(cpu_hold), 32'h0);
    host_addr = 16'h7834; host_we = 1'b1; host_wdata = 8'hD2;
    tick();
    tick();
    check("coll no regrant", 32'(ram_addr), 32'h4812);
    cpu_rd_n = 1'b0;
    tick();
    check("coll cpu addr", 32'(ram_addr), 32'h6044);
    tick();
    check("coll cpu data", 32'(cpu_din), 32'(ref_mem[16'h6044]));
    cpu_rd_n = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (host_ack !== 1'b1 && lat < 30);
    check("coll host after cpu", 32'(lat), 32'd4);
    host_req = 1'b0;
    ref_mem[16'h7834] = 8'hD2;
    tick();
    check("coll hold cycles", 32'(hold_cnt - hold0), 32'd1);

    // tie: CPU strobe and host request in the same IDLE cycle
    cpu_ads_n = 1'b0; cpu_dout = 8'hA7; cpu_addr = 12'h0C0;
    tick();
    cpu_ads_n = 1'b1; cpu_rd_n = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h7834;
    tick();
    check("tie cpu first", 32'(ram_addr), 32'h70C0);
    tick();
    check("tie cpu data", 32'(cpu_din), 32'(ref_mem[16'h70C0]));
    check("tie no early ack", 32'(host_ack), 32'h0);
    cpu_rd_n = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (host_ack !== 1'b1 && lat < 30);
    check("tie host after cpu", 32'(lat), 32'd4);
    check("tie host data", 32'(host_rdata), 32'hD2);
    host_req = 1'b0;
    tick();

    // reset while the host access is in its data cycle
    ack0 = ack_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h2000;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst host_ack",   32'(host_ack),   32'h0);
    check("rst ram_addr",   32'(ram_addr),   32'h0);
    check("rst ram_we",     32'(ram_we),     32'h0);
    check("rst host_rdata", 32'(host_rdata), 32'h0);
    check("rst cpu_flags",  32'(cpu_flags),  32'h0);
    check("rst cpu_hold",   32'(cpu_hold),   32'h0);
    check("rst wp_err",     32'(wp_err),     32'h0);
    host_req = 1'b0;
    rst = 1'b0;
    tick();
    check("rst no ack pulse", 32'(ack_cnt - ack0), 32'd0);
    host_access(1'b0, 16'h2000, 8'h00, rd, lat);
    check("rst reissue data", 32'(rd), 32'h77);

    // random concurrent traffic; CPU uses offsets 0x0xx, host uses 0x8xx
    fork
      begin : cpu_proc
        logic [7:0]  c_ads, c_wd, c_rd;
        logic [11:0] c_a;
        logic        c_wr;
        int          c_wp0;
        for (int i = 0; i < 40; i++) begin
          c_ads = 8'($urandom);
          c_a   = {4'h0, 8'($urandom)};
          c_wr  = 1'($urandom_range(0, 1));
          c_wd  = 8'($urandom);
          c_wp0 = wp_cnt;
          cpu_access(c_ads, c_a, c_wr, c_wd, c_rd);
          if (!c_wr) check("rand cpu data", 32'(c_rd), 32'(ref_mem[{c_ads[3:0], c_a}]));
          check("rand cpu wp", 32'(wp_cnt - c_wp0), 32'((c_wr && !MASK[c_ads[3:0]]) ? 1 : 0));
          check("rand cpu flags", 32'(cpu_flags), 32'(c_ads[7:4]));
        end
      end
      begin : host_proc
        logic [15:0] h_a;
        logic [7:0]  h_wd, h_rd;
        logic        h_we;
        int          h_lat;
        for (int i = 0; i < 40; i++) begin
          h_a  = {4'($urandom), 4'h8, 8'($urandom)};
          h_we = 1'($urandom_range(0, 1));
          h_wd = 8'($urandom);
          host_access(h_we, h_a, h_wd, h_rd, h_lat);
          if (!h_we) check("rand host data", 32'(h_rd), 32'(ref_mem[h_a]));
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
